// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   - parity-mode constants selecting the PARITY parameter value
//   - receiver FSM state encoding
//   - width helpers for FIFO pointers and occupancy counters
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

   // Pointer width for a FIFO of the given depth (depth is a power of two).
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy counter width: one extra bit so that "depth" itself fits.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_wr_en    write request (accepted when not full, or when full and a pop
//              happens in the same cycle)
//   i_wr_data  write word
//   i_rd_en    pop request (ignored when empty)
//   o_rd_data  head word, forced to 0 while empty
//   o_empty    no words stored
//   o_full     DEPTH words stored
//   o_count    current occupancy
module sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
)(
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_wr_en,
   input  logic [WIDTH-1:0]              i_wr_data,
   input  logic                          i_rd_en,
   output logic [WIDTH-1:0]              o_rd_data,
   output logic                          o_empty,
   output logic                          o_full,
   output logic [count_width(DEPTH)-1:0] o_count
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = count_width(DEPTH);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic w_empty;
   logic w_full;
   logic w_do_rd;
   logic w_do_wr;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_COUNT);

   // A pop in the same cycle frees the slot a full FIFO needs for the write.
   assign w_do_rd = i_rd_en && !w_empty;
   assign w_do_wr = i_wr_en && (!w_full || w_do_rd);

   always_ff @(posedge i_clk) begin
      if (w_do_wr)
         r_mem[r_wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_wr)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_do_rd)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         unique case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Memory is not reset; gating with empty keeps the head word at 0 after reset.
   assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_empty   = w_empty;
   assign o_full    = w_full;
   assign o_count   = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver feeding a first-word-fall-through receive FIFO.
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   tick        one-cycle pulse at OVERSAMPLE x baud rate
//   rx          serial input, asynchronous, idle high
//   rd_en       pop request (ignored when empty)
//   clr_err     clears the sticky error flags
//   rd_data     FIFO head word
//   empty/full  FIFO status
//   count       FIFO occupancy
//   parity_err  sticky parity error
//   frame_err   sticky framing (stop bit) error
//   overrun     sticky "good frame dropped because FIFO full"
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | line idle, waiting for a synchronised falling edge on rx
// ST_START  | half a bit period in, confirm start bit is still low
// ST_DATA   | sample DATA_BITS payload bits, LSB first, one per bit period
// ST_PARITY | sample and check the parity bit (PARITY != PAR_NONE only)
// ST_STOP   | sample STOP_BITS stop bits; any low stop bit kills the frame
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          tick,
   input  logic                          rx,
   input  logic                          rd_en,
   input  logic                          clr_err,
   output logic [DATA_BITS-1:0]          rd_data,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overrun
);

   localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TW-1:0] HALF_RELOAD = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] BIT_RELOAD  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_RELOAD = BW'(DATA_BITS - 1);
   localparam logic          STOP_RELOAD = (STOP_BITS == 2);

   // rx synchroniser plus one delayed copy for falling-edge detection
   logic r_rx_meta;
   logic r_rx_sync;
   logic r_rx_prev;

   rx_state_t            r_state;
   logic [TW-1:0]        r_tick_cnt;
   logic [BW-1:0]        r_bit_cnt;
   logic                 r_stop_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_bad;
   logic                 r_wr_pend;
   logic                 r_parity_err;
   logic                 r_frame_err;
   logic                 r_overrun;

   rx_state_t            w_state_nxt;
   logic [TW-1:0]        w_tick_nxt;
   logic [BW-1:0]        w_bit_nxt;
   logic                 w_stop_nxt;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic                 w_bad_nxt;
   logic                 w_par_evt;
   logic                 w_frm_evt;
   logic                 w_frame_good;
   logic                 w_ovr_evt;

   logic w_rx;
   logic w_rx_fall;
   logic w_sample;
   logic w_par_xor;
   logic w_par_bad;
   logic w_empty;
   logic w_full;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   assign w_rx      = r_rx_sync;
   // Edge, not level: after a frame with a low stop bit the line may still be
   // low on return to idle, and that must not look like a new start bit.
   assign w_rx_fall = r_rx_prev && !r_rx_sync;

   // The down-counter hitting zero on a tick marks the sampling point.
   assign w_sample  = tick && (r_tick_cnt == '0);

   assign w_par_xor = (^r_shift) ^ w_rx;
   assign w_par_bad = (PARITY == PAR_ODD) ? !w_par_xor : w_par_xor;

   always_comb begin
      w_state_nxt  = r_state;
      w_tick_nxt   = r_tick_cnt;
      w_bit_nxt    = r_bit_cnt;
      w_stop_nxt   = r_stop_cnt;
      w_shift_nxt  = r_shift;
      w_bad_nxt    = r_bad;
      w_par_evt    = 1'b0;
      w_frm_evt    = 1'b0;
      w_frame_good = 1'b0;

      if (tick && (r_state != ST_IDLE) && (r_tick_cnt != '0))
         w_tick_nxt = r_tick_cnt - TW'(1);

      unique case (r_state)
         ST_IDLE: begin
            if (w_rx_fall) begin
               w_state_nxt = ST_START;
               w_tick_nxt  = HALF_RELOAD;
               w_bad_nxt   = 1'b0;
            end
         end
         ST_START: begin
            if (w_sample) begin
               if (w_rx) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_DATA;
                  w_tick_nxt  = BIT_RELOAD;
                  w_bit_nxt   = DATA_RELOAD;
               end
            end
         end
         ST_DATA: begin
            if (w_sample) begin
               w_shift_nxt = {w_rx, r_shift[DATA_BITS-1:1]};
               w_tick_nxt  = BIT_RELOAD;
               if (r_bit_cnt == '0) begin
                  if (PARITY != PAR_NONE) begin
                     w_state_nxt = ST_PARITY;
                  end else begin
                     w_state_nxt = ST_STOP;
                     w_stop_nxt  = STOP_RELOAD;
                  end
               end else begin
                  w_bit_nxt = r_bit_cnt - BW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (w_sample) begin
               w_state_nxt = ST_STOP;
               w_tick_nxt  = BIT_RELOAD;
               w_stop_nxt  = STOP_RELOAD;
               if (w_par_bad) begin
                  w_bad_nxt = 1'b1;
                  w_par_evt = 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (w_sample) begin
               if (!w_rx) begin
                  w_bad_nxt = 1'b1;
                  w_frm_evt = 1'b1;
               end
               if (r_stop_cnt == 1'b0) begin
                  w_state_nxt  = ST_IDLE;
                  w_frame_good = !r_bad && w_rx;
               end else begin
                  w_stop_nxt = 1'b0;
                  w_tick_nxt = BIT_RELOAD;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_shift    <= '0;
         r_bad      <= 1'b0;
         r_wr_pend  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tick_cnt <= w_tick_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_stop_cnt <= w_stop_nxt;
         r_shift    <= w_shift_nxt;
         r_bad      <= w_bad_nxt;
         // Write happens one edge after the last stop sample; r_shift stays
         // stable until the next frame's first data sample.
         r_wr_pend  <= w_frame_good;
      end
   end

   // A full FIFO only refuses the write if no pop frees a slot this cycle.
   assign w_ovr_evt = r_wr_pend && w_full && !rd_en;

   // New error events take priority over a simultaneous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (w_par_evt)
            r_parity_err <= 1'b1;
         else if (clr_err)
            r_parity_err <= 1'b0;

         if (w_frm_evt)
            r_frame_err <= 1'b1;
         else if (clr_err)
            r_frame_err <= 1'b0;

         if (w_ovr_evt)
            r_overrun <= 1'b1;
         else if (clr_err)
            r_overrun <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk     (clk),
      .i_rst_n   (reset),
      .i_wr_en   (r_wr_pend),
      .i_wr_data (r_shift),
      .i_rd_en   (rd_en),
      .o_rd_data (rd_data),
      .o_empty   (w_empty),
      .o_full    (w_full),
      .o_count   (count)
   );

   assign empty      = w_empty;
   assign full       = w_full;
   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo. Three instances:
//   u_dut0 : 8N1, depth 16
//   u_dut1 : 8 data bits, even parity, depth 16
//   u_dut2 : 8N1, depth 4
// tick is high every other clk, so one bit period is 32 clk cycles.
module tb_uart_rx_fifo;

   logic clk   = 1'b0;
   logic tick  = 1'b0;
   logic reset = 1'b0;
   int   cyc   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      tick <= ~tick;
   end

   logic [2:0] rx_v    = 3'b111;
   logic [2:0] rd_en_v = 3'b000;
   logic [2:0] clr_v   = 3'b000;

   logic [7:0] rd_data0, rd_data1, rd_data2;
   logic [4:0] count0, count1;
   logic [2:0] count2;
   logic [2:0] empty_v, full_v, perr_v, ferr_v, ovr_v;

   uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut0 (
      .clk(clk), .reset(reset), .tick(tick), .rx(rx_v[0]), .rd_en(rd_en_v[0]), .clr_err(clr_v[0]),
      .rd_data(rd_data0), .empty(empty_v[0]), .full(full_v[0]), .count(count0),
      .parity_err(perr_v[0]), .frame_err(ferr_v[0]), .overrun(ovr_v[0]));

   uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut1 (
      .clk(clk), .reset(reset), .tick(tick), .rx(rx_v[1]), .rd_en(rd_en_v[1]), .clr_err(clr_v[1]),
      .rd_data(rd_data1), .empty(empty_v[1]), .full(full_v[1]), .count(count1),
      .parity_err(perr_v[1]), .frame_err(ferr_v[1]), .overrun(ovr_v[1]));

   uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
      .clk(clk), .reset(reset), .tick(tick), .rx(rx_v[2]), .rd_en(rd_en_v[2]), .clr_err(clr_v[2]),
      .rd_data(rd_data2), .empty(empty_v[2]), .full(full_v[2]), .count(count2),
      .parity_err(perr_v[2]), .frame_err(ferr_v[2]), .overrun(ovr_v[2]));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] get_count(input int i);
      case (i)
         0:       return 32'(count0);
         1:       return 32'(count1);
         default: return 32'(count2);
      endcase
   endfunction

   function automatic logic [31:0] get_data(input int i);
      case (i)
         0:       return 32'(rd_data0);
         1:       return 32'(rd_data1);
         default: return 32'(rd_data2);
      endcase
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Return at a negedge inside a cycle where tick is high.
   task automatic align();
      @(negedge clk);
      while (tick !== 1'b1) @(negedge clk);
   endtask

   // Drive a frame starting now; n_send truncates the frame (bits counted from start bit).
   task automatic send_frame(input int i, input logic [7:0] d, input bit has_par,
                             input logic par_bit, input logic stop_val, input int n_send);
      logic [15:0] bits;
      int nb;
      bits    = '1;
      bits[0] = 1'b0;
      for (int k = 0; k < 8; k++) bits[k+1] = d[k];
      nb = 9;
      if (has_par) begin
         bits[nb] = par_bit;
         nb++;
      end
      bits[nb] = stop_val;
      nb++;
      if (n_send < nb) nb = n_send;
      for (int k = 0; k < nb; k++) begin
         rx_v[i] = bits[k];
         repeat (32) @(negedge clk);
      end
      rx_v[i] = 1'b1;
   endtask

   task automatic send_good(input int i, input logic [7:0] d);
      align();
      send_frame(i, d, 1'b0, 1'b0, 1'b1, 99);
      idle(32);
   endtask

   task automatic pop(input int i);
      rd_en_v[i] = 1'b1;
      @(negedge clk);
      rd_en_v[i] = 1'b0;
   endtask

   task automatic pulse_clr(input int i);
      clr_v[i] = 1'b1;
      @(negedge clk);
      clr_v[i] = 1'b0;
   endtask

   typedef struct {
      int         inst;
      logic [7:0] data;
      bit         has_par;
      logic       par_bit;
      logic       stop_val;
      bit         exp_wr;
      bit         exp_perr;
      bit         exp_ferr;
   } vec_t;

   vec_t vecs[10];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      logic [7:0] exp_b;

      vecs[0] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{1, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[8] = '{1, 8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[9] = '{2, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      // ---- reset state
      idle(3);
      check("rst empty",  32'(empty_v), 32'b111);
      check("rst full",   32'(full_v),  32'b000);
      check("rst count0", get_count(0), 0);
      check("rst count2", get_count(2), 0);
      check("rst data0",  get_data(0),  0);
      check("rst perr",   32'(perr_v),  32'b000);
      check("rst ferr",   32'(ferr_v),  32'b000);
      check("rst ovr",    32'(ovr_v),   32'b000);
      reset = 1'b1;
      idle(5);

      // ---- 8N1: 0xA5 with write-latency check, then 0x3C
      align();
      c0 = cyc;
      fork
         send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 99);
         begin
            while (cyc < c0 + 307) @(negedge clk);
            check("A5 empty at stop sample", 32'(empty_v[0]), 1);
            @(negedge clk);
            check("A5 empty 1clk later", 32'(empty_v[0]), 0);
            check("A5 head", get_data(0), 32'hA5);
         end
      join
      idle(32);
      send_good(0, 8'h3C);
      check("two bytes count", get_count(0), 2);
      check("pop1 data", get_data(0), 32'hA5);
      pop(0);
      check("pop2 data", get_data(0), 32'h3C);
      pop(0);
      check("after pops empty", 32'(empty_v[0]), 1);
      check("after pops data", get_data(0), 0);
      check("8N1 flags", {perr_v[0], ferr_v[0], ovr_v[0]}, 0);

      // ---- table-driven frames
      for (int v = 0; v < 10; v++) begin
         int i;
         i = vecs[v].inst;
         pulse_clr(i);
         align();
         send_frame(i, vecs[v].data, vecs[v].has_par, vecs[v].par_bit, vecs[v].stop_val, 99);
         idle(32);
         check($sformatf("vec%0d count", v), get_count(i), 32'(vecs[v].exp_wr));
         check($sformatf("vec%0d perr", v), 32'(perr_v[i]), 32'(vecs[v].exp_perr));
         check($sformatf("vec%0d ferr", v), 32'(ferr_v[i]), 32'(vecs[v].exp_ferr));
         check($sformatf("vec%0d ovr", v), 32'(ovr_v[i]), 0);
         if (vecs[v].exp_wr) begin
            check($sformatf("vec%0d data", v), get_data(i), 32'(vecs[v].data));
            pop(i);
            check($sformatf("vec%0d empty after pop", v), 32'(empty_v[i]), 1);
         end
         if (vecs[v].exp_perr || vecs[v].exp_ferr) begin
            pulse_clr(i);
            check($sformatf("vec%0d flags cleared", v), {perr_v[i], ferr_v[i]}, 0);
         end
      end

      // ---- glitch: 4 ticks low on idle rx is a false start
      align();
      rx_v[0] = 1'b0;
      idle(8);
      rx_v[0] = 1'b1;
      idle(400);
      check("glitch count", get_count(0), 0);
      check("glitch flags", {perr_v[0], ferr_v[0], ovr_v[0]}, 0);
      send_good(0, 8'h5A);
      check("after glitch count", get_count(0), 1);
      check("after glitch data", get_data(0), 32'h5A);
      pop(0);

      // ---- frame error set in the same edge as clr_err: error wins
      align();
      c0 = cyc;
      fork
         send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 99);
         begin
            while (cyc < c0 + 306) @(negedge clk);
            clr_v[0] = 1'b1;
            @(negedge clk);
            clr_v[0] = 1'b0;
            check("ferr beats clr", 32'(ferr_v[0]), 1);
         end
      join
      idle(32);
      check("bad stop no write", get_count(0), 0);
      pulse_clr(0);
      check("ferr cleared", 32'(ferr_v[0]), 0);

      // ---- overrun on depth-4 FIFO
      pulse_clr(2);
      for (int k = 1; k <= 5; k++) send_good(2, 8'(8'h10 * k + k));
      check("ovr full", 32'(full_v[2]), 1);
      check("ovr count", get_count(2), 4);
      check("ovr flag", 32'(ovr_v[2]), 1);
      for (int k = 1; k <= 4; k++) begin
         exp_b = 8'(8'h10 * k + k);
         check($sformatf("ovr pop%0d", k), get_data(2), 32'(exp_b));
         pop(2);
      end
      check("ovr drained", 32'(empty_v[2]), 1);
      pulse_clr(2);
      check("ovr cleared", 32'(ovr_v[2]), 0);

      // ---- full FIFO, pop in the write cycle: byte accepted, no overrun
      for (int k = 1; k <= 4; k++) send_good(2, 8'(8'h60 + k));
      align();
      c0 = cyc;
      fork
         send_frame(2, 8'h65, 1'b0, 1'b0, 1'b1, 99);
         begin
            while (cyc < c0 + 307) @(negedge clk);
            check("full before simult", 32'(full_v[2]), 1);
            rd_en_v[2] = 1'b1;
            @(negedge clk);
            rd_en_v[2] = 1'b0;
         end
      join
      idle(32);
      check("simult count", get_count(2), 4);
      check("simult full", 32'(full_v[2]), 1);
      check("simult no ovr", 32'(ovr_v[2]), 0);
      for (int k = 2; k <= 5; k++) begin
         exp_b = 8'(8'h60 + k);
         check($sformatf("simult pop%0d", k), get_data(2), 32'(exp_b));
         pop(2);
      end
      check("simult drained", 32'(empty_v[2]), 1);
      pop(2);
      check("underflow ignored count", get_count(2), 0);
      send_good(2, 8'h3E);
      check("after underflow data", get_data(2), 32'h3E);
      pop(2);

      // ---- reset in the middle of a frame
      send_good(0, 8'h77);
      align();
      send_frame(0, 8'h00, 1'b0, 1'b0, 1'b0, 99);
      idle(32);
      check("pre-rst count", get_count(0), 1);
      check("pre-rst ferr", 32'(ferr_v[0]), 1);
      align();
      send_frame(0, 8'h9A, 1'b0, 1'b0, 1'b1, 4);
      reset = 1'b0;
      #1;
      check("midrst empty", 32'(empty_v[0]), 1);
      check("midrst count", get_count(0), 0);
      check("midrst data", get_data(0), 0);
      check("midrst flags", {perr_v[0], ferr_v[0], ovr_v[0]}, 0);
      idle(3);
      reset = 1'b1;
      idle(10);
      send_good(0, 8'h12);
      check("post-rst count", get_count(0), 1);
      check("post-rst data", get_data(0), 32'h12);
      check("post-rst flags", {perr_v[0], ferr_v[0], ovr_v[0]}, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
